// File: rtl/fetch_exec_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_exec_sequencer
// Top-level FETCH -> DECODE -> EXEC sequencer for the 3-bit Forth core. It owns
// the single RAM port for both instruction fetch and data access. It also
// provides run/step control, memory wait states with a timeout fault, and a
// retired-instruction counter.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   run          level, continuous execution while high
//   step         one-cycle pulse, executes a single instruction from IDLE
//   fetch_data   RAM read data (opcode) during FETCH
//   xtra         extra-opcode field (regT) from the datapath
//   mem_ready    RAM access completes this cycle
//   mem_req      RAM access request
//   mem_we       RAM write, valid with mem_req
//   addr_sel     0 = regI (fetch) address, 1 = decoder muxA data address
//   ir           latched opcode for the decoder
//   ir_load      opcode captured this cycle
//   regP         decoder execute enable (one cycle per instruction)
//   commit       datapath register update strobe
//   busy         sequencer is in FETCH, DECODE or EXEC
//   fault        sticky memory timeout
//   instr_count  retired instructions, wraps
//   state        encoded state (see table below)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | 0: waiting for run or a step pulse
// FETCH  | 1: reading the opcode from RAM at regI
// DECODE | 2: regP asserted, decoder resolves the opcode
// EXEC   | 3: data access (if any) and commit, then retire
// FAULT  | 7: memory timeout, held until reset
// -----------------------------------------------------------------------------
module fetch_exec_sequencer #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             step,
   input  logic [2:0]       fetch_data,
   input  logic [2:0]       xtra,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic [2:0]       ir,
   output logic             ir_load,
   output logic             regP,
   output logic             commit,
   output logic             busy,
   output logic             fault,
   output logic [CNT_W-1:0] instr_count,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_FAULT  = 3'd7
   } state_t;

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT);

   localparam logic [2:0] OP_RIT = 3'b001;
   localparam logic [2:0] OP_GET = 3'b010;
   localparam logic [2:0] OP_YNK = 3'b011;
   localparam logic [2:0] OP_DBL = 3'b100;
   localparam logic [2:0] OP_MIN = 3'b101;

   state_t             state_q;
   state_t             state_nxt;
   logic [2:0]         ir_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               step_mode_q;
   logic [WAIT_W-1:0]  wait_left_q;

   logic               rd_op;
   logic               wr_op;
   logic               mem_op;
   logic               mem_access;
   logic               tmo_hit;
   logic               retire;
   logic               step_set;

   // Only xtra[2] qualifies YNK; the low bits belong to the datapath.
   logic unused_xtra;
   assign unused_xtra = ^xtra[1:0];

   assign rd_op  = (ir_q == OP_GET) || (ir_q == OP_MIN) || ((ir_q == OP_YNK) && xtra[2]);
   assign wr_op  = (ir_q == OP_RIT) || (ir_q == OP_DBL);
   assign mem_op = rd_op || wr_op;

   assign mem_access = (state_q == ST_FETCH) || ((state_q == ST_EXEC) && mem_op);

   // Down-counter loaded with TIMEOUT on every state entry; reaching zero while
   // still not ready means TIMEOUT+1 consecutive not-ready cycles have elapsed.
   assign tmo_hit = (TIMEOUT != 0) && !mem_ready && (wait_left_q == '0);

   always_comb begin
      state_nxt = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_load   = 1'b0;
      regP      = 1'b0;
      commit    = 1'b0;
      retire    = 1'b0;
      step_set  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_nxt = ST_FETCH;
            end else if (step) begin
               state_nxt = ST_FETCH;
               step_set  = 1'b1;
            end
         end
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_load   = 1'b1;
               state_nxt = ST_DECODE;
            end else if (tmo_hit) begin
               state_nxt = ST_FAULT;
            end
         end
         ST_DECODE: begin
            regP      = 1'b1;
            state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            if (mem_op) begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               mem_we   = wr_op;
               if (mem_ready) begin
                  commit = 1'b1;
                  retire = 1'b1;
               end else if (tmo_hit) begin
                  state_nxt = ST_FAULT;
               end
            end else begin
               commit = 1'b1;
               retire = 1'b1;
            end
            if (retire) begin
               state_nxt = (run && !step_mode_q) ? ST_FETCH : ST_IDLE;
            end
         end
         ST_FAULT: begin
            state_nxt = ST_FAULT;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ir_q        <= 3'd0;
         cnt_q       <= '0;
         step_mode_q <= 1'b0;
         wait_left_q <= '0;
      end else begin
         state_q <= state_nxt;

         if (ir_load) begin
            ir_q <= fetch_data;
         end

         if (retire) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end

         if (step_set) begin
            step_mode_q <= 1'b1;
         end else if (retire) begin
            step_mode_q <= 1'b0;
         end

         if (state_nxt != state_q) begin
            wait_left_q <= WAIT_LOAD;
         end else if (mem_access && !mem_ready && (wait_left_q != '0)) begin
            wait_left_q <= wait_left_q - WAIT_W'(1);
         end
      end
   end

   assign ir          = ir_q;
   assign instr_count = cnt_q;
   assign state       = state_q;
   assign busy        = (state_q == ST_FETCH) || (state_q == ST_DECODE) || (state_q == ST_EXEC);
   assign fault       = (state_q == ST_FAULT);

endmodule
